// File: rtl/serial_adder_ctrl_pkg.sv
// rtl/serial_adder_ctrl_pkg.sv - shared state encodings for the bit-serial adder controller
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_adder_ctrl_complete_adder.sv
// rtl/serial_adder_ctrl_complete_adder.sv - single-bit full adder cell
module complete_adder (
  output logic s,
  output logic c_out,
  input  logic c_in,
  input  logic x,
  input  logic y
);

  assign s     = x ^ y ^ c_in;
  assign c_out = (x & y) | (c_in & (x ^ y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder built on one full-adder cell
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_s;
  logic fa_co;

  complete_adder u_fa (
    .s     (fa_s),
    .c_out (fa_co),
    .c_in  (carry_q),
    .x     (sa_q[0]),
    .y     (sb_q[0])
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    carry_d = carry_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      SA_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = SA_RUN;
        end
      end
      SA_RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == LAST_BIT) begin
          // res_d already holds all WIDTH sum bits aligned to bit 0
          sum_d   = res_d;
          cout_d  = fa_co;
          cnt_d   = '0;
          state_d = SA_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SA_DONE: state_d = SA_IDLE;
      default: state_d = SA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SA_IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy  = (state_q == SA_RUN);
  assign done  = (state_q == SA_DONE);
  assign sum   = sum_q;
  assign c_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       c_out;

  int total;
  int bad;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vc;
    logic [7:0] es;
    logic       ec;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issues one request at the next negedge and follows it to the done pulse.
  task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         input logic [7:0] es, input logic ec, input string nm);
    int k;
    int busy_low;
    @(negedge clk);
    a = ta; b = tb_v; c_in = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
    k = 0;
    busy_low = 0;
    while (!done && k < 20) begin
      if (!busy) busy_low++;
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, k, 8);
    chk({nm, " busy_gaps"}, busy_low, 0);
    chk({nm, " busy_at_done"}, busy, 0);
    chk({nm, " sum"}, sum, es);
    chk({nm, " c_out"}, c_out, ec);
    @(negedge clk);
    chk({nm, " done_width"}, done, 0);
    chk({nm, " sum_hold"}, sum, es);
  endtask

  initial begin
    int k;
    int seen;
    int last_t;
    int pulses;

    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; c_in = 1'b0;

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sum", sum, 8'h00);
    chk("rst c_out", c_out, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_add(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].ec, $sformatf("vec%0d", i));

    // start pulsed again at E3 must be ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 3;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ign latency", k, 8);
    chk("ign sum", sum, 8'h30);
    chk("ign c_out", c_out, 0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("ign no_second", seen, 0);
    chk("ign sum_hold", sum, 8'h30);

    // reset sampled at E4 aborts the operation
    @(negedge clk);
    a = 8'h0F; b = 8'h01; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort sum", sum, 8'h00);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort no_done", seen, 0);
    run_add(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, "after_abort");

    // start together with reset is dropped
    @(negedge clk);
    a = 8'h01; b = 8'h01; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    chk("rst_start busy", busy, 0);
    @(negedge clk);
    chk("rst_start busy2", busy, 0);

    // start held high: one result every WIDTH+2 cycles
    a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
    pulses = 0;
    last_t = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done) begin
        chk("b2b sum", sum, 8'h02);
        if (last_t >= 0) chk("b2b period", t - last_t, 10);
        last_t = t;
        pulses++;
      end
    end
    start = 1'b0;
    chk("b2b pulses", pulses, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
